// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder and its address decoder.
// The default map lives here so the EXE-side address generation agrees with this block.
package data_mem_responder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned WORD_BYTES        = 4;
    localparam int unsigned DEFAULT_DEPTH     = 64;
    localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/data_mem_responder_mem_addr_decode.sv
// Combinational byte-address to word-index translation with a legality flag.
module mem_addr_decode
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned IDX_W     = 6
) (
    input  logic [31:0]      i_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_legal
);

    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    logic [31:0] w_offset;
    logic [31:0] w_word;
    logic        w_above_base;
    logic        w_aligned;
    logic        w_in_range;

    // A wrapped subtraction below the base is harmless: w_above_base rejects it.
    assign w_offset     = i_addr - BASE_ADDR;
    assign w_word       = w_offset >> WORD_SHIFT;
    assign w_above_base = (i_addr >= BASE_ADDR);
    assign w_aligned    = (i_addr[WORD_SHIFT-1:0] == '0);
    assign w_in_range   = (w_word < DEPTH);

    assign o_idx   = w_word[IDX_W-1:0];
    assign o_legal = w_above_base && w_aligned && w_in_range;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: services loads/stores against a word array with a
// fixed access latency, holding the upstream pipeline via freeze while busy.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        memREn,
    input  logic        memWEn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        freeze,
    output logic        addr_err
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        HAS_WAIT = (WAIT_CYCLES != 0);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_load;
    logic             r_legal;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [31:0]      r_mem [DEPTH];

    logic             w_req;
    logic             w_addr_ok;
    logic [IDX_W-1:0] w_idx;
    logic             w_legal_now;
    logic             w_idle_done;
    logic             w_busy_done;
    logic             w_done;
    logic             w_c_load;
    logic             w_c_legal;
    logic [IDX_W-1:0] w_c_idx;
    logic [31:0]      w_c_wdata;

    mem_addr_decode #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_decode (
        .i_addr  (addr),
        .o_idx   (w_idx),
        .o_legal (w_addr_ok)
    );

    assign w_req       = memREn | memWEn;
    assign w_legal_now = w_addr_ok && !(memREn && memWEn);

    // A zero-wait build completes in the presentation cycle straight from the live inputs;
    // otherwise completion uses the request latched on entry to BUSY.
    assign w_idle_done = (r_state == IDLE) && w_req && !HAS_WAIT;
    assign w_busy_done = (r_state == BUSY) && (r_cnt == '0);
    assign w_done      = rest && (w_idle_done || w_busy_done);

    assign w_c_load  = w_busy_done ? r_load  : memREn;
    assign w_c_legal = w_busy_done ? r_legal : w_legal_now;
    assign w_c_idx   = w_busy_done ? r_idx   : w_idx;
    assign w_c_wdata = w_busy_done ? r_wdata : wdata;

    always_comb begin
        rdata    = '0;
        rvalid   = 1'b0;
        addr_err = 1'b0;
        freeze   = rest && (((r_state == IDLE) && w_req && HAS_WAIT) ||
                            ((r_state == BUSY) && (r_cnt != '0)));
        if (w_done) begin
            if (!w_c_legal) begin
                addr_err = 1'b1;
            end else if (w_c_load) begin
                rdata  = r_mem[w_c_idx];
                rvalid = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_legal <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && HAS_WAIT) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_INIT;
                        r_load  <= memREn;
                        r_legal <= w_legal_now;
                        r_idx   <= w_idx;
                        r_wdata <= wdata;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; contents survive rest.
    always_ff @(posedge clk) begin
        if (w_done && w_c_legal && !w_c_load) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=3 instance and a zero-wait instance.
module tb_data_mem_responder;

    logic clk;
    logic rest;

    logic        a_ren, a_wen;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_rvalid, a_freeze, a_err;

    logic        b_ren, b_wen;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_rvalid, b_freeze, b_err;

    int n_vec = 0;
    int n_err = 0;

    data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) u_dut_a (
        .clk      (clk),
        .rest     (rest),
        .memREn   (a_ren),
        .memWEn   (a_wen),
        .addr     (a_addr),
        .wdata    (a_wdata),
        .rdata    (a_rdata),
        .rvalid   (a_rvalid),
        .freeze   (a_freeze),
        .addr_err (a_err)
    );

    data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk      (clk),
        .rest     (rest),
        .memREn   (b_ren),
        .memWEn   (b_wen),
        .addr     (b_addr),
        .wdata    (b_wdata),
        .rdata    (b_rdata),
        .rvalid   (b_rvalid),
        .freeze   (b_freeze),
        .addr_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Present one request on instance A, count freeze cycles, capture completion outputs,
    // then drop the request right after the completion edge.
    task automatic access_a(input logic ren, input logic wen, input logic [31:0] ad,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic rv, output logic err, output int fz,
                            output logic done);
        a_ren = ren; a_wen = wen; a_addr = ad; a_wdata = wd;
        fz = 0; done = 1'b0; rd = 'x; rv = 1'bx; err = 1'bx;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (a_freeze) begin
                fz++;
                @(posedge clk); #1;
            end else begin
                rd = a_rdata; rv = a_rvalid; err = a_err;
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        a_ren = 1'b0; a_wen = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rv, err, done;
    int          fz;
    logic [31:0] bad_addr [4];
    logic        bad_ren  [4];
    logic        bad_wen  [4];

    initial begin
        rest = 1'b0;
        a_ren = 0; a_wen = 1; a_addr = 1024; a_wdata = 32'hCAFE0000;
        b_ren = 0; b_wen = 0; b_addr = 0;    b_wdata = 0;

        // Reset state, with a store request held on A to show nothing leaks out.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_freeze", a_freeze, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_a_err",    a_err,    0);
        check("rst_a_rdata",  a_rdata,  0);
        check("rst_b_freeze", b_freeze, 0);
        a_wen = 0;
        rest = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_a_freeze", a_freeze, 0);
        check("idle_a_rvalid", a_rvalid, 0);
        @(posedge clk); #1;

        // Seed words 1 and 2 with known values.
        access_a(0, 1, 1028, 32'h11111111, rd, rv, err, fz, done);
        check("seed1_done", done, 1);
        check("seed1_err",  err,  0);
        access_a(0, 1, 1032, 32'h22222222, rd, rv, err, fz, done);
        check("seed2_done", done, 1);

        // Test 1: reset during BUSY abandons the store.
        a_wen = 1; a_addr = 1028; a_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("t1_busy_freeze", a_freeze, 1);
        @(negedge clk);
        rest = 1'b0;
        #1;
        check("t1_rst_freeze", a_freeze, 0);
        check("t1_rst_rvalid", a_rvalid, 0);
        a_wen = 0;
        @(negedge clk);
        rest = 1'b1;
        @(posedge clk); #1;
        access_a(1, 0, 1028, 0, rd, rv, err, fz, done);
        check("t1_load_done",  done, 1);
        check("t1_load_rdata", rd,   32'h11111111);
        check("t1_load_rvalid", rv,  1);

        // Test 2: store then load, three freeze cycles each.
        access_a(0, 1, 1024, 32'h12345678, rd, rv, err, fz, done);
        check("t2_st_done",   done, 1);
        check("t2_st_freeze", fz,   3);
        check("t2_st_rvalid", rv,   0);
        access_a(1, 0, 1024, 0, rd, rv, err, fz, done);
        check("t2_ld_freeze", fz,   3);
        check("t2_ld_rvalid", rv,   1);
        check("t2_ld_rdata",  rd,   32'h12345678);
        check("t2_ld_err",    err,  0);

        // Test 3: back-to-back store/load; the store's completion cycle is the only low gap.
        access_a(0, 1, 1028, 32'hA5A5A5A5, rd, rv, err, fz, done);
        check("t3_st_freeze", fz, 3);
        access_a(1, 0, 1028, 0, rd, rv, err, fz, done);
        check("t3_ld_freeze", fz, 3);
        check("t3_ld_rdata",  rd, 32'hA5A5A5A5);
        check("t3_ld_rvalid", rv, 1);

        // Test 4: illegal requests (below base, misaligned, past end, both enables).
        bad_addr[0] = 1020;         bad_ren[0] = 1; bad_wen[0] = 0;
        bad_addr[1] = 1026;         bad_ren[1] = 1; bad_wen[1] = 0;
        bad_addr[2] = 1024 + 4*64;  bad_ren[2] = 1; bad_wen[2] = 0;
        bad_addr[3] = 1024;         bad_ren[3] = 1; bad_wen[3] = 1;
        for (int k = 0; k < 4; k++) begin
            access_a(bad_ren[k], bad_wen[k], bad_addr[k], 32'hBAD0BAD0, rd, rv, err, fz, done);
            check($sformatf("t4_%0d_err",    k), err, 1);
            check($sformatf("t4_%0d_rvalid", k), rv,  0);
            check($sformatf("t4_%0d_rdata",  k), rd,  0);
            check($sformatf("t4_%0d_freeze", k), fz,  3);
        end
        access_a(1, 0, 1024, 0, rd, rv, err, fz, done);
        check("t4_mem0_rdata", rd, 32'h12345678);

        // Test 5: address/data changes while BUSY are ignored.
        a_wen = 1; a_addr = 1036; a_wdata = 32'h00000001;
        @(posedge clk); #1;
        a_addr = 1032; a_wdata = 32'hFFFFFFFF;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!a_freeze) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t5_done", done, 1);
        @(posedge clk); #1;
        a_wen = 0;
        access_a(1, 0, 1036, 0, rd, rv, err, fz, done);
        check("t5_mem3", rd, 32'h00000001);
        access_a(1, 0, 1032, 0, rd, rv, err, fz, done);
        check("t5_mem2", rd, 32'h22222222);

        // Test 6: zero-wait instance, store and load on consecutive cycles.
        b_wen = 1; b_addr = 1024; b_wdata = 32'h55;
        @(negedge clk);
        check("t6_st_freeze", b_freeze, 0);
        check("t6_st_rvalid", b_rvalid, 0);
        check("t6_st_err",    b_err,    0);
        @(posedge clk); #1;
        b_wen = 0; b_ren = 1;
        @(negedge clk);
        check("t6_ld_freeze", b_freeze, 0);
        check("t6_ld_rvalid", b_rvalid, 1);
        check("t6_ld_rdata",  b_rdata,  32'h55);
        @(posedge clk); #1;
        b_addr = 1026;
        @(negedge clk);
        check("t6_bad_err",    b_err,    1);
        check("t6_bad_rvalid", b_rvalid, 0);
        check("t6_bad_rdata",  b_rdata,  0);
        @(posedge clk); #1;
        b_ren = 0;
        @(negedge clk);
        check("t6_idle_err",   b_err,    0);
        check("t6_idle_freeze", b_freeze, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the execute stage's memory request interface: read enable, write enable, ALU-result address and Rm store data.
- Sits in the MEM stage. It translates the byte address to a word index, services loads and stores against an internal word array, and models a fixed access latency.
- While an access is in flight it drives `freeze` high so the upstream pipeline holds.
- In the completion cycle it returns load data, and the MEM/WB register captures it.

Parameters:
- DEPTH, 64: number of 32-bit words in the array.
- BASE_ADDR, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 3: extra cycles per access, range 0..15. A value of 0 gives a single-cycle access.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rest  in  1  reset, asynchronous, active-low.
- memREn  in  1  load request.
- memWEn  in  1  store request.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (Rm value).
- rdata  out  32  load data, valid only when rvalid=1, otherwise 0.
- rvalid  out  1  high in the completion cycle of a legal load.
- freeze  out  1  high while the upstream stage must hold.
- addr_err  out  1  high in the completion cycle of an illegal request.

Behaviour:
- Reset (rest=0, asynchronous):
  - state=IDLE, cnt=0, latched request registers cleared.
  - freeze=0, rvalid=0, addr_err=0, rdata=0.
  - Array contents are NOT cleared.
  - Reset mid-access abandons the access: a pending store is never committed.
- Request: req = memREn | memWEn, sampled only in IDLE.
- Legality checks:
  - addr >= BASE_ADDR.
  - addr[1:0] == 0.
  - idx = (addr - BASE_ADDR) >> 2, with idx < DEPTH.
  - Not both memREn and memWEn high.
  - Any failed check makes the request illegal.
- Illegal request handling:
  - Same timing as a legal request.
  - No array write.
  - rdata=0, rvalid=0.
  - addr_err=1 for exactly the completion cycle.
- FSM states: IDLE and BUSY; cnt is 4 bits.
- IDLE, req=0: all outputs 0 and the state stays IDLE.
- IDLE, req=1, WAIT_CYCLES=0 (cycle T is the completion cycle):
  - freeze=0.
  - A load drives rdata=mem[idx] combinationally with rvalid=1.
  - A store writes mem[idx]=wdata at the end-of-T edge.
  - The state stays IDLE, so the next cycle can accept a new request.
- IDLE, req=1, WAIT_CYCLES>0:
  - freeze=1 combinationally in cycle T.
  - At the edge: latch kind, idx, wdata and legality; cnt=WAIT_CYCLES-1; go to BUSY.
- BUSY, cnt>0: freeze=1, cnt decrements; inputs are ignored.
- BUSY, cnt==0 (completion cycle):
  - freeze=0.
  - A load drives rdata=mem[idx_latched] with rvalid=1.
  - A store commits at the edge.
  - Go to IDLE.
- Timing summary:
  - Total latency is WAIT_CYCLES+1 cycles from presentation to completion.
  - freeze is high for exactly WAIT_CYCLES cycles per access.
- Back-to-back requests:
  - A request held after completion is treated as a new access, one cycle later in IDLE.
  - The upstream stage must deassert or replace the request when freeze falls.
- Read-after-write: a load completing after a store's commit edge returns the new data.
- Input changes while BUSY have no effect, because the request was latched.
- Address arithmetic is 32-bit unsigned; the subtraction never wraps into a legal index because of the addr >= BASE_ADDR check.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, BUSY).
  - The WORD_BYTES=4 constant.
  - The default BASE_ADDR and DEPTH values, so the EXE-side address generation and this block agree.
- One natural sub-module, mem_addr_decode: combinational; maps addr to idx plus a legal flag.
- The FSM, counter and array stay in the top module.

Test Plan:
1. Reset mid-access (WAIT_CYCLES=3): store addr=1028 wdata=0xDEADBEEF, pull rest low during the BUSY cycle, release, then load 1028 -> the load returns the previously written value, not 0xDEADBEEF; freeze=0 immediately on reset.
2. Store then load (WAIT_CYCLES=3): store addr=1024 wdata=0x12345678 -> freeze high 3 cycles; then load 1024 -> freeze high 3 cycles, rvalid=1 and rdata=0x12345678 in the 4th cycle.
3. Back-to-back (WAIT_CYCLES=3): store 1028=0xA5A5A5A5 immediately followed by load 1028 -> the load returns 0xA5A5A5A5; freeze low for exactly one cycle between the two accesses.
4. Illegal addresses: load addr=1020, load addr=1026, load addr=1024+4*64, and memREn=memWEn=1 at 1024 -> each gives addr_err=1 in its completion cycle, rvalid=0, rdata=0, and mem[0] is unchanged.
5. Input glitch while BUSY: change addr/wdata to 1032/0xFFFFFFFF during BUSY of a store 1036=0x1 -> mem[3]=0x1 and mem[2] is unchanged.
6. WAIT_CYCLES=0 build: store 1024=0x55 and load 1024 on consecutive cycles -> freeze never asserts; the load cycle shows rvalid=1, rdata=0x55.
